// File: rtl/bram32_arbiter_pkg.sv
// Shared types and constants for the bram32 read/write arbiter.
// Holds the BRAM geometry defaults and the read-owner tag encoding.
package bram32_arbiter_pkg;

   localparam int BRAM_ADDR_WIDTH = 10;
   localparam int BRAM_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      ARB_OWNER_NONE = 2'b00,
      ARB_OWNER_IFU  = 2'b01,
      ARB_OWNER_LSU  = 2'b10
   } arb_owner_e;

endpackage

// File: rtl/bram32_resp_pipe.sv
// Owner tag shift register that tracks which requester owns each in-flight BRAM read.
// The tag leaving the last stage becomes the one-hot rvalid pair.
module bram32_resp_pipe
   import bram32_arbiter_pkg::*;
#(
   parameter int DEPTH = 1
)(
   input  logic       clk,
   input  logic       rst,
   input  arb_owner_e tag_in,
   output logic       ifu_rvalid,
   output logic       lsu_rvalid
);

   arb_owner_e stage [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= ARB_OWNER_NONE;
      end else begin
         stage[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
   end

   assign ifu_rvalid = (stage[DEPTH-1] == ARB_OWNER_IFU);
   assign lsu_rvalid = (stage[DEPTH-1] == ARB_OWNER_LSU);

endmodule

// File: rtl/bram32_arbiter.sv
// Shares one bram32 between instruction fetch (read-only) and the LSU (read/write).
// Defining BRAM_ARB_STATS_EN adds ifu_stall_cnt / lsu_rd_cnt statistics outputs.
module bram32_arbiter
   import bram32_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH   = BRAM_ADDR_WIDTH,
   parameter int DATA_WIDTH   = BRAM_DATA_WIDTH,
   parameter int READ_LATENCY = 1,
   parameter int STARVE_LIMIT = 4
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  ifu_req,
   input  logic [ADDR_WIDTH-1:0] ifu_addr,
   output logic                  ifu_gnt,
   output logic                  ifu_rvalid,
   output logic [DATA_WIDTH-1:0] ifu_rdata,
   input  logic                  lsu_req,
   input  logic                  lsu_we,
   input  logic [ADDR_WIDTH-1:0] lsu_addr,
   input  logic [DATA_WIDTH-1:0] lsu_wdata,
   input  logic [3:0]            lsu_be,
   output logic                  lsu_gnt,
   output logic                  lsu_rvalid,
   output logic [DATA_WIDTH-1:0] lsu_rdata,
   output logic [ADDR_WIDTH-1:0] bram_w_addr,
   output logic [DATA_WIDTH-1:0] bram_w_dat,
   output logic                  bram_w_enb,
   output logic [3:0]            bram_byte_enb,
   output logic [ADDR_WIDTH-1:0] bram_r_addr,
   output logic                  bram_r_enb,
   input  logic [DATA_WIDTH-1:0] bram_r_dat
`ifdef BRAM_ARB_STATS_EN
   ,
   output logic [31:0]           ifu_stall_cnt,
   output logic [31:0]           lsu_rd_cnt
`endif
);

   localparam int            SW         = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   logic [SW-1:0]         starve_cnt;
   logic [ADDR_WIDTH-1:0] r_addr_q;
   logic                  lsu_wr;
   logic                  lsu_rd;
   logic                  hazard;
   logic                  ifu_win;
   logic                  lsu_win;
   arb_owner_e            winner;

   // An IFU read colliding with a same-cycle LSU write is deferred so it sees the new data.
   always_comb begin
      lsu_wr  = lsu_req & lsu_we;
      lsu_rd  = lsu_req & ~lsu_we;
      hazard  = lsu_wr & ifu_req & (ifu_addr == lsu_addr);
      ifu_win = ~rst & ifu_req & ~hazard & (~lsu_rd | (starve_cnt == STARVE_MAX));
      lsu_win = ~rst & lsu_rd & ~ifu_win;
      winner  = ifu_win ? ARB_OWNER_IFU : (lsu_win ? ARB_OWNER_LSU : ARB_OWNER_NONE);
   end

   assign ifu_gnt       = ifu_win;
   assign lsu_gnt       = (~rst & lsu_wr) | lsu_win;
   assign bram_w_enb    = ~rst & lsu_wr;
   assign bram_w_addr   = lsu_addr;
   assign bram_w_dat    = lsu_wdata;
   assign bram_byte_enb = lsu_be;
   assign bram_r_enb    = ifu_win | lsu_win;
   assign bram_r_addr   = rst ? '0 : (ifu_win ? ifu_addr : (lsu_win ? lsu_addr : r_addr_q));
   assign ifu_rdata     = bram_r_dat;
   assign lsu_rdata     = bram_r_dat;

   always_ff @(posedge clk) begin
      if (rst) begin
         starve_cnt <= '0;
         r_addr_q   <= '0;
      end else begin
         if (ifu_win) starve_cnt <= '0;
         else if (ifu_req && starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + SW'(1);
         if (bram_r_enb) r_addr_q <= bram_r_addr;
      end
   end

   bram32_resp_pipe #(
      .DEPTH (READ_LATENCY)
   ) u_resp_pipe (
      .clk        (clk),
      .rst        (rst),
      .tag_in     (winner),
      .ifu_rvalid (ifu_rvalid),
      .lsu_rvalid (lsu_rvalid)
   );

`ifdef BRAM_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         ifu_stall_cnt <= '0;
         lsu_rd_cnt    <= '0;
      end else begin
         if (ifu_req && !ifu_win && ifu_stall_cnt != 32'hFFFF_FFFF) ifu_stall_cnt <= ifu_stall_cnt + 32'd1;
         if (lsu_win && lsu_rd_cnt != 32'hFFFF_FFFF) lsu_rd_cnt <= lsu_rd_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bram32_arbiter.sv
// Bench for bram32_arbiter: directed scenarios followed by random traffic, with a
// behavioural BRAM, a reference arbitration model and a decoupled rvalid scoreboard.
module tb_bram32_arbiter;
   import bram32_arbiter_pkg::*;

   localparam int AW = 10;
   localparam int DW = 32;
   localparam int RL = 2;
   localparam int SL = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          ifu_req, ifu_gnt, ifu_rvalid;
   logic [AW-1:0] ifu_addr;
   logic [DW-1:0] ifu_rdata;
   logic          lsu_req, lsu_we, lsu_gnt, lsu_rvalid;
   logic [AW-1:0] lsu_addr;
   logic [DW-1:0] lsu_wdata, lsu_rdata;
   logic [3:0]    lsu_be;
   logic [AW-1:0] bram_w_addr, bram_r_addr;
   logic [DW-1:0] bram_w_dat, bram_r_dat;
   logic          bram_w_enb, bram_r_enb;
   logic [3:0]    bram_byte_enb;

   always #5 clk = ~clk;

   bram32_arbiter #(
      .ADDR_WIDTH   (AW),
      .DATA_WIDTH   (DW),
      .READ_LATENCY (RL),
      .STARVE_LIMIT (SL)
   ) u_dut (
      .clk           (clk),
      .rst           (rst),
      .ifu_req       (ifu_req),
      .ifu_addr      (ifu_addr),
      .ifu_gnt       (ifu_gnt),
      .ifu_rvalid    (ifu_rvalid),
      .ifu_rdata     (ifu_rdata),
      .lsu_req       (lsu_req),
      .lsu_we        (lsu_we),
      .lsu_addr      (lsu_addr),
      .lsu_wdata     (lsu_wdata),
      .lsu_be        (lsu_be),
      .lsu_gnt       (lsu_gnt),
      .lsu_rvalid    (lsu_rvalid),
      .lsu_rdata     (lsu_rdata),
      .bram_w_addr   (bram_w_addr),
      .bram_w_dat    (bram_w_dat),
      .bram_w_enb    (bram_w_enb),
      .bram_byte_enb (bram_byte_enb),
      .bram_r_addr   (bram_r_addr),
      .bram_r_enb    (bram_r_enb),
      .bram_r_dat    (bram_r_dat)
   );

   // Behavioural bram32 with RL-cycle read latency.
   logic [DW-1:0] mem     [0:(1<<AW)-1];
   logic [DW-1:0] ref_mem [0:(1<<AW)-1];
   logic [DW-1:0] rpipe   [RL];

   always @(posedge clk) begin
      if (bram_w_enb)
         for (int b = 0; b < 4; b++)
            if (bram_byte_enb[b]) mem[bram_w_addr][8*b +: 8] <= bram_w_dat[8*b +: 8];
      if (bram_r_enb) rpipe[0] <= mem[bram_r_addr];
      for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
   end
   assign bram_r_dat = rpipe[RL-1];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   typedef struct {
      int            due;
      logic [DW-1:0] data;
   } exp_t;

   exp_t ifu_q[$];
   exp_t lsu_q[$];

   // Reference model: arbitration rules applied to the cycle's inputs.
   int            starve = 0;
   logic [AW-1:0] last_raddr = '0;
   logic          m_wr, m_rd, m_haz, e_ifu, e_lsu;

   always @(negedge clk) begin
      m_wr = lsu_req && lsu_we;
      m_rd = lsu_req && !lsu_we;
      if (rst) begin
         chk("rst_ifu_gnt", ifu_gnt, 0);
         chk("rst_lsu_gnt", lsu_gnt, 0);
         chk("rst_w_enb", bram_w_enb, 0);
         chk("rst_r_enb", bram_r_enb, 0);
         chk("rst_r_addr", bram_r_addr, 0);
         starve     = 0;
         last_raddr = '0;
         while (ifu_q.size() > 0 && ifu_q[$].due > cyc) void'(ifu_q.pop_back());
         while (lsu_q.size() > 0 && lsu_q[$].due > cyc) void'(lsu_q.pop_back());
      end else begin
         m_haz = m_wr && ifu_req && (ifu_addr == lsu_addr);
         e_ifu = ifu_req && !m_haz && (!m_rd || starve == SL);
         e_lsu = m_rd && !e_ifu;
         chk("ifu_gnt", ifu_gnt, e_ifu);
         chk("lsu_gnt", lsu_gnt, m_wr || e_lsu);
         chk("w_enb", bram_w_enb, m_wr);
         chk("r_enb", bram_r_enb, e_ifu || e_lsu);
         if (m_wr) begin
            chk("w_addr", bram_w_addr, lsu_addr);
            chk("w_dat", bram_w_dat, lsu_wdata);
            chk("byte_enb", bram_byte_enb, lsu_be);
         end
         if (e_ifu) begin
            chk("r_addr_ifu", bram_r_addr, ifu_addr);
            ifu_q.push_back('{cyc + RL, ref_mem[ifu_addr]});
            last_raddr = ifu_addr;
         end else if (e_lsu) begin
            chk("r_addr_lsu", bram_r_addr, lsu_addr);
            lsu_q.push_back('{cyc + RL, ref_mem[lsu_addr]});
            last_raddr = lsu_addr;
         end else begin
            chk("r_addr_hold", bram_r_addr, last_raddr);
         end
         if (e_ifu) starve = 0;
         else if (ifu_req && starve < SL) starve++;
         if (m_wr)
            for (int b = 0; b < 4; b++)
               if (lsu_be[b]) ref_mem[lsu_addr][8*b +: 8] = lsu_wdata[8*b +: 8];
      end
   end

   // Monitor: every rvalid pops its requester's queue; an overdue entry is a miss.
   exp_t mi, ml;
   always @(negedge clk) begin
      chk("rvalid_onehot", ifu_rvalid && lsu_rvalid, 0);
      if (ifu_rvalid) begin
         if (ifu_q.size() == 0) chk("ifu_spurious_rvalid", ifu_rvalid, 0);
         else begin
            mi = ifu_q.pop_front();
            chk("ifu_rvalid_cycle", cyc, mi.due);
            chk("ifu_rdata", ifu_rdata, mi.data);
         end
      end else if (ifu_q.size() > 0 && ifu_q[0].due <= cyc) begin
         void'(ifu_q.pop_front());
         chk("ifu_rvalid_missing", ifu_rvalid, 1);
      end
      if (lsu_rvalid) begin
         if (lsu_q.size() == 0) chk("lsu_spurious_rvalid", lsu_rvalid, 0);
         else begin
            ml = lsu_q.pop_front();
            chk("lsu_rvalid_cycle", cyc, ml.due);
            chk("lsu_rdata", lsu_rdata, ml.data);
         end
      end else if (lsu_q.size() > 0 && lsu_q[0].due <= cyc) begin
         void'(lsu_q.pop_front());
         chk("lsu_rvalid_missing", lsu_rvalid, 1);
      end
   end

   logic gi_seen = 1'b0;
   logic gl_seen = 1'b0;
   always @(negedge clk) begin
      gi_seen = ifu_gnt;
      gl_seen = lsu_gnt;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int ifu_wins, deny_run, max_deny;

   initial begin
      for (int a = 0; a < (1<<AW); a++) begin
         mem[a]     = $urandom;
         ref_mem[a] = mem[a];
      end
      for (int i = 0; i < RL; i++) rpipe[i] = '0;
      rst = 1'b1;
      ifu_req = 1'b0; ifu_addr = '0;
      lsu_req = 1'b0; lsu_we = 1'b0; lsu_addr = '0; lsu_wdata = '0; lsu_be = 4'h0;
      repeat (3) step();
      rst = 1'b0;

      // Preload a small program image through the write port.
      for (int a = 0; a < 16; a++) begin
         lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = AW'(a); lsu_wdata = $urandom; lsu_be = 4'hF;
         step();
      end
      lsu_req = 1'b0;

      // IFU-only fetch of words 0..3 on consecutive cycles.
      for (int a = 0; a < 4; a++) begin
         ifu_req = 1'b1; ifu_addr = AW'(a);
         step();
      end
      ifu_req = 1'b0;
      repeat (RL + 1) step();

      // LSU write then read-back of the same word.
      lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 10'd5; lsu_wdata = 32'hDEADBEEF; lsu_be = 4'hF;
      step();
      lsu_we = 1'b0;
      step();
      chk("lsu_read_gnt", gl_seen, 1);
      lsu_req = 1'b0;
      repeat (RL + 1) step();

      // Both requesters read continuously: starvation guard lets IFU in every 5th cycle.
      ifu_req = 1'b1; ifu_addr = 10'd20;
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 10'd40;
      ifu_wins = 0; deny_run = 0; max_deny = 0;
      for (int n = 0; n < 15; n++) begin
         step();
         if (gi_seen) begin
            ifu_wins++; deny_run = 0; ifu_addr = ifu_addr + 10'd1;
         end else begin
            deny_run++;
            if (deny_run > max_deny) max_deny = deny_run;
         end
         if (gl_seen) lsu_addr = lsu_addr + 10'd1;
      end
      chk("starve_ifu_wins", ifu_wins, 3);
      chk("starve_max_deny", max_deny, SL);
      ifu_req = 1'b0; lsu_req = 1'b0;
      repeat (RL + 1) step();

      // Same-address write/read hazard defers the IFU by one cycle.
      lsu_req = 1'b1; lsu_we = 1'b1; lsu_addr = 10'd7; lsu_wdata = 32'hA5A5_1234; lsu_be = 4'hF;
      ifu_req = 1'b1; ifu_addr = 10'd7;
      step();
      chk("hazard_ifu_denied", gi_seen, 0);
      lsu_req = 1'b0;
      step();
      chk("hazard_retry_gnt", gi_seen, 1);
      ifu_req = 1'b0;
      repeat (RL + 1) step();

      // Reset right after an IFU grant drops the in-flight read.
      ifu_req = 1'b1; ifu_addr = 10'd3;
      step();
      ifu_req = 1'b0;
      rst = 1'b1;
      lsu_req = 1'b1; lsu_we = 1'b0; lsu_addr = 10'd2;
      step();
      chk("rst_lsu_held_no_gnt", gl_seen, 0);
      rst = 1'b0;
      lsu_req = 1'b0;
      repeat (RL + 2) step();

      // Random traffic with held requests and occasional resets.
      for (int n = 0; n < 800; n++) begin
         if (!ifu_req || gi_seen) begin
            ifu_req  = ($urandom_range(0, 3) != 0);
            ifu_addr = AW'($urandom_range(0, 15));
         end
         if (!lsu_req || gl_seen) begin
            lsu_req   = ($urandom_range(0, 2) != 0);
            lsu_we    = $urandom_range(0, 1) == 1;
            lsu_addr  = AW'($urandom_range(0, 15));
            lsu_wdata = $urandom;
            lsu_be    = 4'($urandom_range(0, 15));
         end
         rst = ($urandom_range(0, 99) == 0);
         step();
      end
      rst = 1'b0; ifu_req = 1'b0; lsu_req = 1'b0;
      repeat (RL + 3) step();
      chk("ifu_queue_drained", ifu_q.size(), 0);
      chk("lsu_queue_drained", lsu_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
